// File: rtl/div_sequencer.sv
// Multi-cycle RV32M divide/remainder sequencer (DIV, DIVU, REM, REMU).
// Radix-2 restoring divider, one quotient bit per clock. Divide-by-zero
// and signed overflow finish in a single cycle with the RISC-V defined results.
module div_sequencer #(
  parameter int XLEN = 32,
  parameter int CNTW = 6
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            START,
  input  logic [1:0]      OP,
  input  logic [XLEN-1:0] DATA1,
  input  logic [XLEN-1:0] DATA2,
  input  logic            FLUSH,
  output logic            READY,
  output logic            BUSY,
  output logic            DONE,
  output logic [XLEN-1:0] RESULT
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  localparam logic [XLEN-1:0] ALL_ONES = '1;
  localparam logic [XLEN-1:0] ZERO     = '0;
  localparam logic [XLEN-1:0] ONE      = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(XLEN - 1);
  localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);

  // Two's complement negation, modulo 2^XLEN.
  function automatic logic [XLEN-1:0] neg2c(input logic [XLEN-1:0] v);
    return ~v + ONE;
  endfunction

  // Magnitude of a signed operand; the most negative value maps to itself
  // and is then treated as an unsigned magnitude.
  function automatic logic [XLEN-1:0] mag(input logic signed [XLEN-1:0] v);
    logic [XLEN-1:0] u;
    u = v;
    return v[XLEN-1] ? neg2c(u) : u;
  endfunction

  // Apply the recorded result sign.
  function automatic logic [XLEN-1:0] fix_sign(input logic [XLEN-1:0] v, input logic neg);
    return neg ? neg2c(v) : v;
  endfunction

  state_t          state_q, state_d;
  logic            op_rem_q, op_rem_d;
  logic            qneg_q, qneg_d;
  logic            rneg_q, rneg_d;
  logic [XLEN-1:0] dvsr_q, dvsr_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] result_q, result_d;

  logic            in_signed;
  logic [XLEN-1:0] data1_mag, data2_mag;
  logic [XLEN:0]   trial;
  logic            trial_ok;
  logic [XLEN-1:0] rem_step, quo_step;

  assign in_signed = ~OP[0];
  assign data1_mag = in_signed ? mag(DATA1) : DATA1;
  assign data2_mag = in_signed ? mag(DATA2) : DATA2;

  // One restoring step: shift the next dividend bit into the partial
  // remainder and try to subtract the divisor. The subtract is one bit wider
  // so its borrow tells whether the divisor fits.
  assign trial    = {rem_q, quo_q[XLEN-1]} - {1'b0, dvsr_q};
  assign trial_ok = ~trial[XLEN];
  assign rem_step = trial_ok ? trial[XLEN-1:0] : {rem_q[XLEN-2:0], quo_q[XLEN-1]};
  assign quo_step = {quo_q[XLEN-2:0], trial_ok};

  // Next-state and datapath selection for the IDLE/CALC/FIN sequence.
  always_comb begin
    state_d  = state_q;
    op_rem_d = op_rem_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    dvsr_d   = dvsr_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    unique case (state_q)
      S_IDLE: begin
        // FLUSH blocks acceptance even while idle.
        if (START && !FLUSH) begin
          op_rem_d = OP[1];
          qneg_d   = in_signed & (DATA1[XLEN-1] ^ DATA2[XLEN-1]);
          rneg_d   = in_signed & DATA1[XLEN-1];
          if (DATA2 == ZERO) begin
            result_d = OP[1] ? DATA1 : ALL_ONES;
            state_d  = S_FIN;
          end else if (in_signed && DATA1 == MIN_NEG && DATA2 == ALL_ONES) begin
            result_d = OP[1] ? ZERO : DATA1;
            state_d  = S_FIN;
          end else begin
            dvsr_d  = data2_mag;
            rem_d   = ZERO;
            quo_d   = data1_mag;
            cnt_d   = CNT_LAST;
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (FLUSH) begin
          state_d = S_IDLE;
        end else begin
          rem_d = rem_step;
          quo_d = quo_step;
          cnt_d = cnt_q - CNT_ONE;
          // Final iteration: publish the sign-corrected result directly.
          if (cnt_q == '0) begin
            result_d = op_rem_q ? fix_sign(rem_step, rneg_q) : fix_sign(quo_step, qneg_q);
            cnt_d    = '0;
            state_d  = S_FIN;
          end
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; async reset clears everything.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      op_rem_q <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      dvsr_q   <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_rem_q <= op_rem_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      dvsr_q   <= dvsr_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign READY  = (state_q == S_IDLE);
  assign BUSY   = (state_q == S_CALC);
  assign DONE   = (state_q == S_FIN);
  assign RESULT = result_q;

endmodule
